ssd1306_spi_tx: RTL and testbench

// Byte-level 4-wire SPI transmitter driving the SSD1306 panel (SCLK, MOSI, CS_n, D/C).

---
 rtl/ssd1306_pkg.sv | 24 ++
 rtl/ssd1306_phase_timer.sv | 26 ++
 rtl/ssd1306_spi_tx.sv | 168 ++++++++++++++++
 tb/tb_ssd1306_spi_tx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ssd1306_pkg.sv
// Shared types and default SPI timing for the SSD1306 display path.
package ssd1306_pkg;

  typedef enum logic [2:0] {
    ST_RST,
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_t;

  localparam int unsigned SPI_CLK_DIV_DEF  = 4;
  localparam int unsigned SPI_CS_SETUP_DEF = 2;
  localparam int unsigned SPI_CS_HOLD_DEF  = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ssd1306_phase_timer.sv
// Loadable down-counter; tick is high while the count sits at zero.
module ssd1306_phase_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk_in,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  logic [W-1:0] count;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/ssd1306_spi_tx.sv
// Byte-level mode-0 SPI transmitter for the SSD1306 with CS_n burst framing.
module ssd1306_spi_tx
  import ssd1306_pkg::*;
#(
  parameter int unsigned CLK_DIV  = SPI_CLK_DIV_DEF,
  parameter int unsigned CS_SETUP = SPI_CS_SETUP_DEF,
  parameter int unsigned CS_HOLD  = SPI_CS_HOLD_DEF
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       command_start,
  input  logic [7:0] command_in,
  input  logic       command_dc,
  input  logic       command_last_byte,
  output logic       command_ready,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_csn,
  output logic       oled_dc
);

  localparam int unsigned TW = $clog2(max3(CLK_DIV, CS_SETUP, CS_HOLD) + 1);

  // The phase entered on accept runs one cycle longer than its nominal length;
  // this is the accept cycle that appears in the byte-time budget.
  localparam logic [TW-1:0] LD_SETUP_FIRST = TW'(CS_SETUP);
  localparam logic [TW-1:0] LD_DIV_FIRST   = TW'(CLK_DIV);
  localparam logic [TW-1:0] LD_DIV         = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] LD_HOLD        = TW'(CS_HOLD - 1);

  spi_state_t    state, state_d;
  logic [7:0]    shreg, shreg_d;
  logic [2:0]    bit_cnt, bit_d;
  logic          last, last_d;
  logic          csn_d, sclk_d, mosi_d, dc_d, ready_d;
  logic          load;
  logic [TW-1:0] load_val;
  logic          tick;

  ssd1306_phase_timer #(.W(TW)) u_timer (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (load_val),
    .tick     (tick)
  );

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_RST;
      shreg         <= '0;
      bit_cnt       <= '0;
      last          <= 1'b0;
      spi_csn       <= 1'b1;
      spi_sclk      <= 1'b0;
      spi_mosi      <= 1'b0;
      oled_dc       <= 1'b0;
      command_ready <= 1'b0;
    end else begin
      state         <= state_d;
      shreg         <= shreg_d;
      bit_cnt       <= bit_d;
      last          <= last_d;
      spi_csn       <= csn_d;
      spi_sclk      <= sclk_d;
      spi_mosi      <= mosi_d;
      oled_dc       <= dc_d;
      command_ready <= ready_d;
    end
  end

  always_comb begin
    state_d  = state;
    shreg_d  = shreg;
    bit_d    = bit_cnt;
    last_d   = last;
    csn_d    = spi_csn;
    sclk_d   = spi_sclk;
    mosi_d   = spi_mosi;
    dc_d     = oled_dc;
    ready_d  = command_ready;
    load     = 1'b0;
    load_val = '0;

    unique case (state)
      ST_RST: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end

      ST_IDLE: begin
        if (command_start && command_ready) begin
          ready_d = 1'b0;
          shreg_d = command_in;
          mosi_d  = command_in[7];
          dc_d    = command_dc;
          last_d  = command_last_byte;
          bit_d   = 3'd7;
          csn_d   = 1'b0;
          load    = 1'b1;
          if (spi_csn && (CS_SETUP != 0)) begin
            state_d  = ST_SETUP;
            load_val = LD_SETUP_FIRST;
          end else begin
            state_d  = ST_SHIFT;
            load_val = LD_DIV_FIRST;
          end
        end
      end

      ST_SETUP: begin
        if (tick) begin
          state_d  = ST_SHIFT;
          load     = 1'b1;
          load_val = LD_DIV;
        end
      end

      ST_SHIFT: begin
        if (tick) begin
          load     = 1'b1;
          load_val = LD_DIV;
          if (!spi_sclk) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt == 3'd0) begin
              if (!last) begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
              end else if (CS_HOLD == 0) begin
                state_d = ST_IDLE;
                csn_d   = 1'b1;
                ready_d = 1'b1;
              end else begin
                state_d  = ST_HOLD;
                load_val = LD_HOLD;
              end
            end else begin
              bit_d   = bit_cnt - 3'd1;
              shreg_d = {shreg[6:0], 1'b0};
              mosi_d  = shreg[6];
            end
          end
        end
      end

      ST_HOLD: begin
        if (tick) begin
          state_d  = ST_GAP;
          csn_d    = 1'b1;
          load     = 1'b1;
          load_val = LD_HOLD;
        end
      end

      ST_GAP: begin
        if (tick) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end

      default: state_d = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_ssd1306_spi_tx.sv
// Scoreboard bench for ssd1306_spi_tx: two instances (CLK_DIV=2 and CLK_DIV=1).
module tb_ssd1306_spi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_n, start, dc_in, last_in;
  logic [1:0][7:0] din;
  logic [1:0]      ready, sclk, mosi, csn, dc;
  logic            ready0, sclk0, mosi0, csn0, dc0;
  logic            ready1, sclk1, mosi1, csn1, dc1;

  assign ready = {ready1, ready0};
  assign sclk  = {sclk1, sclk0};
  assign mosi  = {mosi1, mosi0};
  assign csn   = {csn1, csn0};
  assign dc    = {dc1, dc0};

  ssd1306_spi_tx #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1)) dut0 (
    .clk_in(clk), .reset_n(rst_n[0]), .command_start(start[0]), .command_in(din[0]),
    .command_dc(dc_in[0]), .command_last_byte(last_in[0]), .command_ready(ready0),
    .spi_sclk(sclk0), .spi_mosi(mosi0), .spi_csn(csn0), .oled_dc(dc0)
  );

  ssd1306_spi_tx #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) dut1 (
    .clk_in(clk), .reset_n(rst_n[1]), .command_start(start[1]), .command_in(din[1]),
    .command_dc(dc_in[1]), .command_last_byte(last_in[1]), .command_ready(ready1),
    .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_csn(csn1), .oled_dc(dc1)
  );

  int checks = 0;
  int failures = 0;

  function automatic void check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  // Expected {dc, byte} per instance.
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  // Monitor state
  logic [1:0] prev_sclk, prev_mosi, prev_dc, prev_csn, prev_ready, prev_rst;
  int         nbits[2];
  logic [7:0] sh[2];
  int         csn_rises[2];

  initial begin
    prev_sclk = '0; prev_mosi = '0; prev_dc = '0; prev_csn = '1;
    prev_ready = '0; prev_rst = '0;
    for (int d = 0; d < 2; d++) begin
      nbits[d] = 0; sh[d] = '0; csn_rises[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n[d] || !prev_rst[d]) begin
          nbits[d] = 0;
        end else begin
          if (sclk[d])
            check($sformatf("dut%0d mosi_stable_while_sclk_high", d),
                  int'(mosi[d]), int'(prev_mosi[d]));
          if (dc[d] != prev_dc[d]) begin
            check($sformatf("dut%0d dc_change_only_on_accept", d),
                  int'(prev_ready[d] && !ready[d]), 1);
            check($sformatf("dut%0d dc_change_sclk_low", d), int'(sclk[d]), 0);
          end
          if (!prev_sclk[d] && sclk[d]) begin
            check($sformatf("dut%0d csn_low_before_rise", d),
                  int'({prev_csn[d], csn[d]}), 0);
            sh[d] = {sh[d][6:0], mosi[d]};
            nbits[d]++;
            if (nbits[d] == 8) begin
              logic [8:0] exp;
              int         have;
              nbits[d] = 0;
              have = 0;
              exp = '0;
              if (d == 0 && q0.size() > 0) begin exp = q0.pop_front(); have = 1; end
              if (d == 1 && q1.size() > 0) begin exp = q1.pop_front(); have = 1; end
              check($sformatf("dut%0d byte_expected", d), have, 1);
              if (have != 0)
                check($sformatf("dut%0d byte_dc_value", d), int'({dc[d], sh[d]}), int'(exp));
            end
          end
          if (!prev_csn[d] && csn[d]) csn_rises[d]++;
        end
      end
      prev_sclk = sclk; prev_mosi = mosi; prev_dc = dc; prev_csn = csn;
      prev_ready = ready; prev_rst = rst_n;
    end
  end

  task automatic send(input int d, input logic [7:0] b, input logic dv, input logic lst,
                      input int exp_cyc, input bit hold2, input string name);
    int n;
    n = 0;
    while (!ready[d] && n < 200) begin @(posedge clk); #1; n++; end
    check({name, " ready_before_accept"}, int'(ready[d]), 1);
    if (d == 0) q0.push_back({dv, b}); else q1.push_back({dv, b});
    din[d] = b; dc_in[d] = dv; last_in[d] = lst; start[d] = 1'b1;
    @(posedge clk); #1;
    if (!hold2) start[d] = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (hold2 && n == 1) start[d] = 1'b0;
    end while (!ready[d] && n < 500);
    check({name, " accept_to_ready_cycles"}, n, exp_cyc);
  endtask

  task automatic check_reset_outputs(input int d, input string name);
    check({name, " csn"}, int'(csn[d]), 1);
    check({name, " sclk"}, int'(sclk[d]), 0);
    check({name, " mosi"}, int'(mosi[d]), 0);
    check({name, " dc"}, int'(dc[d]), 0);
    check({name, " ready"}, int'(ready[d]), 0);
  endtask

  // Reset asserted during the low phase of bit 4; that byte is never expected.
  task automatic mid_reset(input int d, input logic [7:0] b, input string name);
    int n;
    din[d] = b; dc_in[d] = 1'b1; last_in[d] = 1'b1; start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    n = 0;
    while (nbits[d] != 3 && n < 200) begin @(posedge clk); #1; n++; end
    check({name, " reached_bit4"}, nbits[d], 3);
    n = 0;
    while (sclk[d] && n < 20) begin @(posedge clk); #1; n++; end
    #2;
    rst_n[d] = 1'b0;
    #1;
    check_reset_outputs(d, {name, " async"});
    @(posedge clk); @(posedge clk); #1;
    rst_n[d] = 1'b1;
    @(posedge clk); #1;
    check({name, " ready_one_edge_after_release"}, int'(ready[d]), 1);
    check({name, " csn_after_release"}, int'(csn[d]), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    rst_n = '0; start = '1; din = '1; dc_in = '1; last_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs(0, "reset0");
    check_reset_outputs(1, "reset1");
    rst_n = '1;
    @(posedge clk); #1;
    check("reset0 ready_after_1_edge", int'(ready[0]), 1);
    check("reset1 ready_after_1_edge", int'(ready[1]), 1);
    check("reset0 no_accept_on_release", int'(csn[0]), 1);
    check("reset1 no_accept_on_release", int'(csn[1]), 1);
    start = '0; dc_in = '0;

    send(0, 8'hA5, 1'b0, 1'b1, 36, 1'b0, "single_a5");
    check("gap_csn_high_before_burst", int'(csn[0]), 1);

    r0 = csn_rises[0];
    send(0, 8'hAE, 1'b0, 1'b0, 34, 1'b0, "burst_ae");
    check("burst csn_low_between_bytes", int'(csn[0]), 0);
    send(0, 8'hD5, 1'b1, 1'b0, 33, 1'b0, "burst_d5");
    send(0, 8'h80, 1'b1, 1'b1, 35, 1'b0, "burst_80");
    check("burst csn_rises", csn_rises[0] - r0, 1);
    check("burst csn_high_after_last", int'(csn[0]), 1);

    send(0, 8'h3C, 1'b1, 1'b1, 36, 1'b1, "held_start_3c");
    repeat (40) @(posedge clk);
    #1;
    check("held_start single_byte_only", q0.size(), 0);
    check("held_start idle_ready", int'(ready[0]), 1);
    check("held_start idle_csn", int'(csn[0]), 1);

    mid_reset(0, 8'h5A, "midreset0");
    send(0, 8'h5A, 1'b1, 1'b1, 36, 1'b0, "after_reset0_5a");

    send(1, 8'hC3, 1'b0, 1'b1, 20, 1'b0, "div1_c3");
    mid_reset(1, 8'h69, "midreset1");
    send(1, 8'h96, 1'b1, 1'b1, 20, 1'b0, "after_reset1_96");

    repeat (20) @(posedge clk);
    #1;
    check("final dut0 queue_empty", q0.size(), 0);
    check("final dut1 queue_empty", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
